hazard_forward_ctrl: RTL and testbench
======================================

# hazard_forward_ctrl

Pipeline hazard and forwarding controller for the 5-stage core. Tracks destination-register state of the instructions in EX, MEM and WB in internal stage records, and drives the 3-bit `forward_detect_EX_rs1/rs2` selects consumed by the EX operand muxes. Generates load-use stalls, branch flushes and full-pipeline freezes. Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and is the only source of their stall/flush controls.

## Interface
- DATA_WIDTH, 32, width of the optional performance counters
- REG_ADDR_WIDTH, 5, register index width
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid_ID  in  1  ID holds a real instruction
- rs1_ID, rs2_ID  in  REG_ADDR_WIDTH  source indices in ID
- rs1_used_ID, rs2_used_ID  in  1  source actually read by the ID instruction
- rd_ID  in  REG_ADDR_WIDTH  destination index in ID
- reg_write_ID  in  1  ID instruction writes rd
- is_load_ID  in  1  ID instruction is a load
- branch_taken_EX  in  1  EX resolved a taken branch/jump this cycle
- mem_busy  in  1  data memory not ready; freeze whole pipeline
- forward_detect_EX_rs1, forward_detect_EX_rs2  out  3  one-hot select; bit 0 = no forward, bit `FORWARD_COLLISION_IN_MEM` (1) = EX/MEM ALU result, bit `FORWARD_COLLISION_IN_WB` (2) = WB result
- stall_IF, stall_ID  out  1  hold PC and IF/ID register
- flush_ID  out  1  clear IF/ID register
- bubble_EX  out  1  load a NOP into ID/EX
- freeze  out  1  hold every pipeline register
- stall_cycles, flush_cycles  out  DATA_WIDTH  performance counters (macro-gated)

## Operation
- Stage records EX, MEM, WB each hold {valid, rd, reg_write, is_load}; EX additionally holds {rs1, rs2, rs1_used, rs2_used}. All reset to 0.
- Advance (no freeze, no stall, no flush): WB←MEM, MEM←EX, EX←ID inputs (valid = instr_valid_ID).
- Load-use: EX.valid & EX.is_load & EX.reg_write & EX.rd≠0 & ((rs1_used_ID & rs1_ID==EX.rd) | (rs2_used_ID & rs2_ID==EX.rd)) & instr_valid_ID → stall_IF=stall_ID=bubble_EX=1; EX record becomes invalid, MEM/WB advance.
- Branch: branch_taken_EX → flush_ID=bubble_EX=1; EX record invalid, MEM←old EX; overrides load-use (stall outputs 0).
- Freeze: mem_busy → freeze=1, all records hold, all other stall/flush outputs 0; overrides branch and load-use (they re-evaluate after release).
- Forward select per operand (s = rs1 or rs2), combinational from records: if EX.s_used & EX.s≠0 & MEM.valid & MEM.reg_write & !MEM.is_load & MEM.rd==EX.s → MEM bit; else if EX.s_used & EX.s≠0 & WB.valid & WB.reg_write & WB.rd==EX.s → WB bit; else bit 0. MEM priority over WB. Output always exactly one-hot.
- A load in MEM never forwards; load-use stall guarantees the consumer sees it in WB.
- x0 never forwarded.

## Timing
- Forward selects: zero-latency from record state (valid same cycle the consumer is in EX).
- Stall/flush/freeze outputs: combinational from inputs and records; record update at next rising edge.
- Load-use costs exactly 1 bubble cycle; consumer then sees WB forward.
- Branch costs 2 squashed instructions (ID and incoming EX).
- Reset asserted mid-operation: next edge clears all records and counters; outputs after that edge: forward selects 3'b001, all stall/flush/freeze 0 except freeze follows mem_busy.
- Simultaneous load-use + branch: branch wins; simultaneous anything + mem_busy: freeze wins.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cycles increments by 1 each cycle stall_ID=1; flush_cycles each cycle flush_ID=1; both wrap modulo 2^DATA_WIDTH, cleared by rst, held during freeze.
- Not defined: counters absent, both outputs tied to 0.

## Test plan
- add x5 in EX→MEM, next instr uses x5 as rs1 → forward_detect_EX_rs1=3'b010, rs2=3'b001.
- x5 written in MEM and WB by two back-to-back adds, consumer reads x5 → 3'b010 (MEM priority).
- lw x6 in EX, ID reads x6 as rs2 → 1 cycle stall_ID=bubble_EX=1; next cycle in EX forward_detect_EX_rs2=3'b100.
- Write to x0 then read x0 → selects stay 3'b001; lw x0 + consumer → no stall.
- branch_taken_EX with load-use pending → flush_ID=bubble_EX=1, stall_ID=0; then mem_busy 3 cycles → freeze=1, records unchanged, selects stable.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls + 1 branch → stall_cycles=2, flush_cycles=1; rst mid-run → both 0 next cycle.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller: EX/MEM/WB dest records, one-hot forward selects,
// load-use stall, branch flush, freeze. Perf counters gated by HAZARD_PERF_CNT_EN.
module hazard_forward_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_ID,
    input  logic                      rs1_used_ID,
    input  logic                      rs2_used_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rd_ID,
    input  logic                      reg_write_ID,
    input  logic                      is_load_ID,
    input  logic                      branch_taken_EX,
    input  logic                      mem_busy,
    output logic [2:0]                forward_detect_EX_rs1,
    output logic [2:0]                forward_detect_EX_rs2,
    output logic                      stall_IF,
    output logic                      stall_ID,
    output logic                      flush_ID,
    output logic                      bubble_EX,
    output logic                      freeze,
    output logic [DATA_WIDTH-1:0]     stall_cycles,
    output logic [DATA_WIDTH-1:0]     flush_cycles
);

    localparam int FORWARD_NONE             = 0;
    localparam int FORWARD_COLLISION_IN_MEM = 1;
    localparam int FORWARD_COLLISION_IN_WB  = 2;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      is_load;
    } rec_t;

    // WB never consults is_load, so it is not carried past MEM
    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
    } wb_rec_t;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic                      rs1_used;
        logic                      rs2_used;
    } src_t;

    rec_t    ex_q, ex_d;
    rec_t    mem_q, mem_d;
    wb_rec_t wb_q, wb_d;
    src_t    src_q, src_d;

    logic load_use;
    logic hit1, hit2;

    always_comb begin
        hit1 = rs1_used_ID && (rs1_ID == ex_q.rd);
        hit2 = rs2_used_ID && (rs2_ID == ex_q.rd);
        load_use = ex_q.valid && ex_q.is_load && ex_q.reg_write
                   && (ex_q.rd != '0) && (hit1 || hit2)
                   && instr_valid_ID;
    end

    // Priority: freeze > branch flush > load-use stall
    always_comb begin
        freeze    = mem_busy;
        flush_ID  = branch_taken_EX && !mem_busy;
        stall_ID  = load_use && !branch_taken_EX && !mem_busy;
        stall_IF  = stall_ID;
        bubble_EX = flush_ID || stall_ID;
    end

    function automatic logic [2:0] fwd_sel(
        input logic                      used,
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input rec_t                      mem,
        input wb_rec_t                   wb
    );
        logic [2:0] sel;
        sel = '0;
        if (used && rs != '0 && mem.valid && mem.reg_write
            && !mem.is_load && mem.rd == rs) begin
            sel[FORWARD_COLLISION_IN_MEM] = 1'b1;
        end else if (used && rs != '0 && wb.valid
                     && wb.reg_write && wb.rd == rs) begin
            sel[FORWARD_COLLISION_IN_WB] = 1'b1;
        end else begin
            sel[FORWARD_NONE] = 1'b1;
        end
        return sel;
    endfunction

    always_comb begin
        forward_detect_EX_rs1 = fwd_sel(src_q.rs1_used, src_q.rs1,
                                        mem_q, wb_q);
        forward_detect_EX_rs2 = fwd_sel(src_q.rs2_used, src_q.rs2,
                                        mem_q, wb_q);
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        src_d = src_q;
        if (!mem_busy) begin
            wb_d.valid     = mem_q.valid;
            wb_d.rd        = mem_q.rd;
            wb_d.reg_write = mem_q.reg_write;
            mem_d          = ex_q;
            if (branch_taken_EX || load_use) begin
                ex_d  = '0;
                src_d = '0;
            end else begin
                ex_d.valid     = instr_valid_ID;
                ex_d.rd        = rd_ID;
                ex_d.reg_write = reg_write_ID;
                ex_d.is_load   = is_load_ID;
                src_d.rs1      = rs1_ID;
                src_d.rs2      = rs2_ID;
                src_d.rs1_used = rs1_used_ID;
                src_d.rs2_used = rs2_used_ID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            src_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            src_q <= src_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [DATA_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [DATA_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // stall_ID/flush_ID are already 0 under freeze, so counters hold then
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_ID) stall_cnt_d = stall_cnt_q + DATA_WIDTH'(1);
        if (flush_ID) flush_cnt_d = flush_cnt_q + DATA_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: forwarding, load-use,
// x0, branch/freeze priority, reset and perf counters.
module tb_hazard_forward_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;

`ifdef HAZARD_PERF_CNT_EN
    localparam int EXP_STALL = 2;
    localparam int EXP_FLUSH = 1;
`else
    localparam int EXP_STALL = 0;
    localparam int EXP_FLUSH = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid_ID;
    logic [AW-1:0] rs1_ID, rs2_ID, rd_ID;
    logic          rs1_used_ID, rs2_used_ID;
    logic          reg_write_ID, is_load_ID;
    logic          branch_taken_EX, mem_busy;
    logic [2:0]    fwd1, fwd2;
    logic          stall_IF, stall_ID, flush_ID, bubble_EX, freeze;
    logic [DW-1:0] stall_cycles, flush_cycles;

    int checks = 0;
    int failures = 0;

    hazard_forward_ctrl #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .instr_valid_ID(instr_valid_ID),
        .rs1_ID(rs1_ID),
        .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID),
        .rs2_used_ID(rs2_used_ID),
        .rd_ID(rd_ID),
        .reg_write_ID(reg_write_ID),
        .is_load_ID(is_load_ID),
        .branch_taken_EX(branch_taken_EX),
        .mem_busy(mem_busy),
        .forward_detect_EX_rs1(fwd1),
        .forward_detect_EX_rs2(fwd2),
        .stall_IF(stall_IF),
        .stall_ID(stall_ID),
        .flush_ID(flush_ID),
        .bubble_EX(bubble_EX),
        .freeze(freeze),
        .stall_cycles(stall_cycles),
        .flush_cycles(flush_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] r1,
                          input logic u1, input logic [AW-1:0] r2,
                          input logic u2, input logic [AW-1:0] rd,
                          input logic we, input logic ld);
        instr_valid_ID = v;
        rs1_ID = r1;
        rs1_used_ID = u1;
        rs2_ID = r2;
        rs2_used_ID = u2;
        rd_ID = rd;
        reg_write_ID = we;
        is_load_ID = ld;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_busy = 1'b0;
        branch_taken_EX = 1'b0;
        nop();
        tick();
        tick();
        settle();
        checks++;
        if (fwd1 !== 3'b001 || fwd2 !== 3'b001) begin
            failures++;
            $display("FAIL reset_fwd got=%b/%b exp=001/001", fwd1, fwd2);
        end
        checks++;
        if ({stall_IF, stall_ID, flush_ID, bubble_EX, freeze} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {stall_IF, stall_ID, flush_ID, bubble_EX, freeze});
        end
        checks++;
        if (stall_cycles !== '0 || flush_cycles !== '0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0",
                     stall_cycles, flush_cycles);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fwd_mem();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd5, 1, 5'd7, 1, 5'd8, 1, 0);
        tick();
        nop();
        settle();
        checks++;
        if (fwd1 !== 3'b010) begin
            failures++;
            $display("FAIL fwd_mem_rs1 got=%b exp=010", fwd1);
        end
        checks++;
        if (fwd2 !== 3'b001) begin
            failures++;
            $display("FAIL fwd_mem_rs2 got=%b exp=001", fwd2);
        end
        drain();
    endtask

    task automatic test_mem_priority();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd9, 1, 5'd5, 1, 5'd10, 1, 0);
        tick();
        nop();
        settle();
        checks++;
        if (fwd2 !== 3'b010) begin
            failures++;
            $display("FAIL mem_prio_rs2 got=%b exp=010", fwd2);
        end
        checks++;
        if (fwd1 !== 3'b001) begin
            failures++;
            $display("FAIL mem_prio_rs1 got=%b exp=001", fwd1);
        end
        drain();
    endtask

    task automatic test_wb_fwd();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0);
        tick();
        set_id(1, 5'd5, 1, 5'd5, 0, 5'd11, 1, 0);
        tick();
        nop();
        settle();
        checks++;
        if (fwd1 !== 3'b100) begin
            failures++;
            $display("FAIL wb_fwd_rs1 got=%b exp=100", fwd1);
        end
        checks++;
        if (fwd2 !== 3'b001) begin
            failures++;
            $display("FAIL wb_unused_rs2 got=%b exp=001", fwd2);
        end
        drain();
    endtask

    task automatic test_load_use();
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
        tick();
        set_id(1, 5'd3, 1, 5'd6, 1, 5'd9, 1, 0);
        settle();
        checks++;
        if ({stall_IF, stall_ID, bubble_EX, flush_ID} !== 4'b1110) begin
            failures++;
            $display("FAIL lu_stall got=%b exp=1110",
                     {stall_IF, stall_ID, bubble_EX, flush_ID});
        end
        tick();
        settle();
        checks++;
        if (stall_ID !== 1'b0 || bubble_EX !== 1'b0) begin
            failures++;
            $display("FAIL lu_one_bubble got=%b%b exp=00",
                     stall_ID, bubble_EX);
        end
        checks++;
        if (fwd2 !== 3'b001) begin
            failures++;
            $display("FAIL lu_bubble_fwd got=%b exp=001", fwd2);
        end
        tick();
        nop();
        settle();
        checks++;
        if (fwd2 !== 3'b100 || fwd1 !== 3'b001) begin
            failures++;
            $display("FAIL lu_wb_fwd got=%b/%b exp=001/100", fwd1, fwd2);
        end
        drain();
    endtask

    task automatic test_x0();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0);
        tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0);
        tick();
        nop();
        settle();
        checks++;
        if (fwd1 !== 3'b001 || fwd2 !== 3'b001) begin
            failures++;
            $display("FAIL x0_fwd got=%b/%b exp=001/001", fwd1, fwd2);
        end
        drain();
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1);
        tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0);
        settle();
        checks++;
        if (stall_ID !== 1'b0 || bubble_EX !== 1'b0) begin
            failures++;
            $display("FAIL x0_no_stall got=%b%b exp=00", stall_ID, bubble_EX);
        end
        tick();
        drain();
    endtask

    task automatic test_branch_freeze();
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
        tick();
        set_id(1, 5'd6, 1, 5'd0, 0, 5'd9, 1, 0);
        branch_taken_EX = 1'b1;
        settle();
        checks++;
        if ({flush_ID, bubble_EX, stall_ID, stall_IF} !== 4'b1100) begin
            failures++;
            $display("FAIL br_over_lu got=%b exp=1100",
                     {flush_ID, bubble_EX, stall_ID, stall_IF});
        end
        tick();
        branch_taken_EX = 1'b0;
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0);
        tick();
        set_id(1, 5'd7, 1, 5'd6, 1, 5'd12, 1, 0);
        tick();
        nop();
        mem_busy = 1'b1;
        branch_taken_EX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (freeze !== 1'b1 || flush_ID !== 1'b0 || bubble_EX !== 1'b0
                || stall_ID !== 1'b0) begin
                failures++;
                $display("FAIL frz_ctrl[%0d] got=%b%b%b%b exp=1000", i,
                         freeze, flush_ID, bubble_EX, stall_ID);
            end
            checks++;
            if (fwd1 !== 3'b010 || fwd2 !== 3'b001) begin
                failures++;
                $display("FAIL frz_fwd[%0d] got=%b/%b exp=010/001", i,
                         fwd1, fwd2);
            end
            tick();
        end
        mem_busy = 1'b0;
        branch_taken_EX = 1'b0;
        settle();
        checks++;
        if (freeze !== 1'b0 || fwd1 !== 3'b010) begin
            failures++;
            $display("FAIL frz_release got=%b/%b exp=0/010", freeze, fwd1);
        end
        tick();
        drain();
    endtask

    task automatic test_perf_cnt();
        rst = 1'b1;
        nop();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
            tick();
            set_id(1, 5'd6, 1, 5'd0, 0, 5'd9, 1, 0);
            tick();
            tick();
        end
        nop();
        branch_taken_EX = 1'b1;
        tick();
        branch_taken_EX = 1'b0;
        settle();
        checks++;
        if (stall_cycles !== DW'(EXP_STALL)) begin
            failures++;
            $display("FAIL cnt_stall got=%0d exp=%0d", stall_cycles, EXP_STALL);
        end
        checks++;
        if (flush_cycles !== DW'(EXP_FLUSH)) begin
            failures++;
            $display("FAIL cnt_flush got=%0d exp=%0d", flush_cycles, EXP_FLUSH);
        end
        tick();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd5, 1, 5'd0, 0, 5'd8, 1, 0);
        tick();
        nop();
        rst = 1'b1;
        mem_busy = 1'b1;
        tick();
        settle();
        checks++;
        if (fwd1 !== 3'b001 || freeze !== 1'b1 || stall_ID !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got=%b/%b/%b exp=001/1/0",
                     fwd1, freeze, stall_ID);
        end
        checks++;
        if (stall_cycles !== '0 || flush_cycles !== '0) begin
            failures++;
            $display("FAIL rst_mid_cnt got=%0d/%0d exp=0/0",
                     stall_cycles, flush_cycles);
        end
        rst = 1'b0;
        mem_busy = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        mem_busy = 1'b0;
        branch_taken_EX = 1'b0;
        nop();
        test_reset();
        test_fwd_mem();
        test_mem_priority();
        test_wb_fwd();
        test_load_use();
        test_x0();
        test_branch_freeze();
        test_perf_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
